// File: rtl/uart_tx_merge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_merge: merges two 8N1 TX lines frame-by-frame onto one pin.      |
// | Optional: UART_MERGE_FERR_EN (drop bad-stop bytes, flag on ferr_o).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_tx_merge #(
  parameter int CLK_FREQ   = 32000000,
  parameter int BAUDRATE   = 1000000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       dbg_txd_i,
  input  logic       uart_txd_i,
  output logic       txd_o,
  output logic       busy_o,
  output logic [1:0] ovf_o,
  output logic [1:0] ferr_o
);

  localparam int c_DIV = CLK_FREQ / BAUDRATE;
  localparam int c_CW  = $clog2(c_DIV);
  localparam int c_AW  = $clog2(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(c_DIV - 1);
  localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(c_DIV / 2 - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
  localparam logic [c_AW:0]   c_PTR_ONE   = (c_AW + 1)'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic [1:0] w_line;
  logic [1:0] w_empty;
  logic [1:0] w_pop;
  logic [1:0] w_ovf;
  logic [1:0] w_ferr;
  logic [7:0] w_rd_data [2];

  assign w_line = {uart_txd_i, dbg_txd_i};

  for (genvar n = 0; n < 2; n++) begin : g_src
    logic            r_s1, r_s2, r_prev;
    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            w_fall, w_stop_sample, w_push, w_armed;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW:0]   r_wr, r_rd;
    logic            r_ovf, w_full, w_wr_en;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_s1   <= 1'b1;
        r_s2   <= 1'b1;
        r_prev <= 1'b1;
      end else begin
        r_s1   <= w_line[n];
        r_s2   <= r_s1;
        r_prev <= r_s2;
      end
    end

    assign w_fall        = r_prev & ~r_s2;
    assign w_stop_sample = (r_state == ST_STOP) && (r_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_bit   <= '0;
        r_shift <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_fall && w_armed) begin
              r_state <= ST_START;
              r_cnt   <= c_HALF_LAST;
            end
          end
          ST_START: begin
            if (r_cnt == '0) begin
              // a start bit that is high again at mid-bit was only a glitch
              if (r_s2) begin
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_DATA;
                r_cnt   <= c_BIT_LAST;
                r_bit   <= '0;
              end
            end else begin
              r_cnt <= r_cnt - c_CNT_ONE;
            end
          end
          ST_DATA: begin
            if (r_cnt == '0) begin
              r_shift <= {r_s2, r_shift[7:1]};
              r_cnt   <= c_BIT_LAST;
              if (r_bit == 3'd7) r_state <= ST_STOP;
              else               r_bit   <= r_bit + 3'd1;
            end else begin
              r_cnt <= r_cnt - c_CNT_ONE;
            end
          end
          ST_STOP: begin
            if (r_cnt == '0) r_state <= ST_IDLE;
            else             r_cnt   <= r_cnt - c_CNT_ONE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end

`ifdef UART_MERGE_FERR_EN
    logic r_ferr, r_wait_high;

    assign w_push   = w_stop_sample & r_s2;
    assign w_armed  = ~r_wait_high;
    assign w_ferr[n] = r_ferr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_ferr      <= 1'b0;
        r_wait_high <= 1'b0;
      end else if (w_stop_sample && !r_s2) begin
        r_ferr      <= 1'b1;
        r_wait_high <= 1'b1;
      end else if (r_s2) begin
        r_wait_high <= 1'b0;
      end
    end
`else
    assign w_push    = w_stop_sample;
    assign w_armed   = 1'b1;
    assign w_ferr[n] = 1'b0;
`endif

    assign w_full     = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
    assign w_empty[n] = (r_wr == r_rd);
    // a simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign w_wr_en    = w_push && (!w_full || w_pop[n]);
    assign w_rd_data[n] = r_mem[r_rd[c_AW-1:0]];
    assign w_ovf[n]   = r_ovf;

    always_ff @(posedge clk_i) begin
      if (w_wr_en) r_mem[r_wr[c_AW-1:0]] <= r_shift;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_wr_en)                        r_wr  <= r_wr + c_PTR_ONE;
        if (w_pop[n])                       r_rd  <= r_rd + c_PTR_ONE;
        if (w_push && w_full && !w_pop[n])  r_ovf <= 1'b1;
      end
    end
  end

  state_t          r_tx_state;
  logic [c_CW-1:0] r_tx_cnt;
  logic [2:0]      r_tx_bit;
  logic [7:0]      r_tx_shift;
  logic            r_last;
  logic            r_txd;
  logic            w_load;
  logic            w_sel;

  always_comb begin
    w_sel = 1'b0;
    if (!w_empty[0] && !w_empty[1]) w_sel = ~r_last;
    else if (w_empty[0])            w_sel = 1'b1;
  end

  assign w_load = (r_tx_state == ST_IDLE) && (w_empty != 2'b11);
  assign w_pop  = {w_load & w_sel, w_load & ~w_sel};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_last     <= 1'b1;
      r_txd      <= 1'b1;
    end else begin
      // the pin follows the state one cycle later, keeping txd_o a clean flop
      case (r_tx_state)
        ST_START: r_txd <= 1'b0;
        ST_DATA:  r_txd <= r_tx_shift[0];
        default:  r_txd <= 1'b1;
      endcase
      case (r_tx_state)
        ST_IDLE: begin
          if (w_load) begin
            r_tx_shift <= w_rd_data[w_sel];
            r_last     <= w_sel;
            r_tx_state <= ST_START;
            r_tx_cnt   <= c_BIT_LAST;
          end
        end
        ST_START: begin
          if (r_tx_cnt == '0) begin
            r_tx_state <= ST_DATA;
            r_tx_cnt   <= c_BIT_LAST;
            r_tx_bit   <= '0;
          end else begin
            r_tx_cnt <= r_tx_cnt - c_CNT_ONE;
          end
        end
        ST_DATA: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt <= c_BIT_LAST;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= ST_STOP;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - c_CNT_ONE;
          end
        end
        ST_STOP: begin
          if (r_tx_cnt == '0) r_tx_state <= ST_IDLE;
          else                r_tx_cnt   <= r_tx_cnt - c_CNT_ONE;
        end
        default: r_tx_state <= ST_IDLE;
      endcase
    end
  end

  assign txd_o  = r_txd;
  assign busy_o = (r_tx_state != ST_IDLE) || (w_empty != 2'b11);
  assign ovf_o  = w_ovf;
  assign ferr_o = w_ferr;

endmodule
`default_nettype wire
